rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between the pipeline WB stage and a multi-cycle long-latency unit (mult/div/load-miss).
- WB has normal priority. Long-unit results queue in a small buffer and drain into idle write-port cycles.
- A starvation counter forces a drain by holding WB.
- A per-register busy scoreboard tells decode which source registers are still awaiting a long-unit result.

Parameters:
DEPTH, 2, entries in the long-unit result buffer (power of two, >=2)
STARVE_MAX, 4, cycles a non-empty buffer may be denied before WB is held (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb_we  in  1  WB stage requests a register write
wb_wa  in  5  WB destination register
wb_wd  in  32  WB write data
wb_hold  out  1  WB write not performed this cycle; pipeline must freeze and re-present it
lu_valid  in  1  long-unit result valid
lu_ready  out  1  buffer can accept a result
lu_wa  in  5  long-unit destination register
lu_wd  in  32  long-unit result data
iss_valid  in  1  decode issues a long-unit op
iss_wa  in  5  destination of the issued op
iss_ready  out  1  issue allowed (destination not busy)
ra1, ra2  in  5  decode source register numbers
rs1_busy, rs2_busy  out  1  source awaits a long-unit result
rf_we  out  1  to register file we3
rf_wa  out  5  to register file wa3
rf_wd  out  32  to register file wd3

Behaviour:
- Reset (async, rst_n low):
  - Buffer empty, busy[31:0]=0, starve_cnt=0.
  - Outputs forced while rst_n low: rf_we=0, wb_hold=0, lu_ready=0.
  - After release: lu_ready=1 and iss_ready=1 while busy=0.
  - A reset mid-operation discards all buffered results and pending busy bits.
- Buffer:
  - FIFO of {wa,wd}, DEPTH entries.
  - Push when lu_valid && lu_ready. lu_ready = !full (combinational from count).
  - No pass-through: a result arriving when the buffer is empty is written no earlier than the next cycle.
  - When full, lu_ready stays 0 even if a pop occurs the same cycle.
  - Simultaneous push and pop while not full is allowed and leaves count unchanged.
- Arbitration (combinational, evaluated every cycle, in priority order):
  1. Buffer non-empty && starve_cnt==STARVE_MAX: grant buffer; wb_hold = wb_we.
  2. Else wb_we: grant WB; wb_hold=0.
  3. Else buffer non-empty: grant buffer.
  4. Else no grant: rf_we=0.
- Write-port drive:
  - Grant WB: rf_wa=wb_wa, rf_wd=wb_wd.
  - Grant buffer: rf_wa/rf_wd come from the head entry, and the head is popped at the clock edge.
  - rf_we=1 on any grant except when rf_wa==0. Writes to r0 are suppressed, but the grant is still consumed: a buffer head with wa 0 is popped.
  - Write latency into the register file is 1 edge after grant.
- starve_cnt:
  - Cleared on pop or when the buffer is empty.
  - Incremented, saturating at STARVE_MAX, when the buffer is non-empty and not granted.
- Scoreboard:
  - iss_ready = !busy[iss_wa] || iss_wa==0.
  - Set busy[iss_wa] on iss_valid && iss_ready && iss_wa!=0.
  - Clear busy[wa] when a buffer entry with that wa is popped.
  - Set and clear of the same register in one cycle cannot occur, because iss_ready is 0 while the register is busy.
- Busy outputs:
  - rs1_busy = busy[ra1] && ra1!=0; rs2_busy likewise.
  - Combinational from registered busy, so a register still reads busy in the cycle its write is granted. Decode stalls one extra cycle; no bypass.
- Protocol errors (simulation assertions only, no RTL recovery):
  - lu push whose lu_wa is not busy.
  - wb_we to a busy register (WAW).
  - iss_valid while iss_ready=0 is legal and simply not accepted.

Decomposition:
- Shared package rf_arb_pkg holds:
  - REG_AW=5, DATA_W=32, NUM_REGS=32.
  - Grant enum {GNT_NONE, GNT_WB, GNT_LU}.
  - Packed struct rf_wr_t {wa, wd}.
- One sub-module, rf_wr_fifo:
  - DEPTH-entry synchronous FIFO of rf_wr_t with async active-low reset.
  - Signals: push/pop/full/empty/head.
- Arbiter, starvation counter and scoreboard stay in rf_write_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 buffered entries and busy[5]=1. Required: rf_we=0 immediately. After release: lu_ready=1, iss_ready=1 for wa 5, rs1_busy=0 for ra1=5.
- Idle drain: issue wa=7, push lu {7,32'hDEADBEEF} with wb_we=0.
  - Next cycle: rf_we=1, rf_wa=7, rf_wd=DEADBEEF.
  - rs1_busy(ra1=7) is 1 that cycle and 0 the following one.
- WB priority/starvation: buffer holds {3,32'h11}, wb_we=1 every cycle, STARVE_MAX=4.
  - WB granted for 4 cycles.
  - 5th cycle: wb_hold=1, rf_wa=3, rf_wd=32'h11.
  - Following cycle: WB granted again, wb_hold=0.
- Full buffer: DEPTH=2, wb_we=1 continuously, push 2 results. Required: lu_ready=0 with lu_valid held; no third push accepted until a forced drain pops one.
- r0 handling: wb_we=1 wb_wa=0 -> rf_we=0. Buffer entry wa=0 -> popped, rf_we=0, count decrements. iss_wa=0 -> iss_ready=1, no busy bit set.
- WAW block: busy[9]=1, iss_valid with iss_wa=9 -> iss_ready=0 until entry 9 pops, then iss_ready=1 on the next cycle.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: widths, grant
// encoding and the {wa,wd} write record carried through the result buffer.
package rf_arb_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LU
  } gnt_e;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO of pending long-unit register writes.
// Storage is not reset; only pointers and occupancy are.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  rf_wr_t wr_data,
  output logic   full,
  output logic   empty,
  output rf_wr_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  rf_wr_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB and buffered long-unit
// results, with starvation forcing and a per-register busy scoreboard.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              wb_hold,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_wa,
  input  logic [DATA_W-1:0] lu_wd,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_wa,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == STARVE_LIM) ? v : v + 4'd1;
  endfunction

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  rf_wr_t              head;
  rf_wr_t              lu_entry;
  gnt_e                gnt;
  logic [3:0]          starve_cnt;
  logic [NUM_REGS-1:0] busy;

  assign lu_entry = {lu_wa, lu_wd};
  assign lu_ready = rst_n && !fifo_full;
  assign push     = lu_valid && lu_ready;
  assign pop      = (gnt == GNT_LU);

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (lu_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // A starved buffer preempts WB; WB then freezes and re-presents its write.
  always_comb begin
    gnt     = GNT_NONE;
    wb_hold = 1'b0;
    if (!fifo_empty && (starve_cnt == STARVE_LIM)) begin
      gnt     = GNT_LU;
      wb_hold = wb_we;
    end else if (wb_we) begin
      gnt = GNT_WB;
    end else if (!fifo_empty) begin
      gnt = GNT_LU;
    end
    if (!rst_n) begin
      gnt     = GNT_NONE;
      wb_hold = 1'b0;
    end
  end

  assign rf_wa = (gnt == GNT_LU) ? head.wa : wb_wa;
  assign rf_wd = (gnt == GNT_LU) ? head.wd : wb_wd;
  assign rf_we = (gnt != GNT_NONE) && (rf_wa != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Set and clear never target the same register: issue is refused while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (pop) busy[head.wa] <= 1'b0;
      if (iss_valid && iss_ready && (iss_wa != '0)) busy[iss_wa] <= 1'b1;
    end
  end

  assign iss_ready = !busy[iss_wa] || (iss_wa == '0);
  assign rs1_busy  = busy[ra1] && (ra1 != '0);
  assign rs2_busy  = busy[ra2] && (ra2 != '0);

`ifndef SYNTHESIS
  lu_push_not_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
    (push && (lu_wa != '0)) |-> busy[lu_wa]);

  wb_waw_a: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_we && (wb_wa != '0)) |-> !busy[wb_wa]);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: constant vector table, directed corner
// sequences, then random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_rf_write_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        wb_hold;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic        iss_ready;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_hold(wb_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_ready(iss_ready),
    .ra1(ra1), .ra2(ra2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual %h, required %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] wa; logic [31:0] wd; } ent_t;
  ent_t       mq[$];
  bit         mbusy[32];
  int         mstarve;
  logic [4:0] outstanding[$];   // issued ops whose result is not yet pushed

  int          m_gnt;           // 0 none, 1 WB, 2 buffer
  logic        e_we, e_hold, e_lr, e_ir, e_rs1, e_rs2;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;

  task automatic model_reset();
    mq.delete();
    outstanding.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mstarve = 0;
  endtask

  task automatic model_eval();
    bit ne;
    ne     = (mq.size() > 0);
    e_hold = 1'b0;
    if (ne && mstarve == STARVE_MAX) begin m_gnt = 2; e_hold = wb_we; end
    else if (wb_we)                  m_gnt = 1;
    else if (ne)                     m_gnt = 2;
    else                             m_gnt = 0;
    e_wa  = (m_gnt == 2) ? mq[0].wa : wb_wa;
    e_wd  = (m_gnt == 2) ? mq[0].wd : wb_wd;
    e_we  = (m_gnt != 0) && (e_wa != 0);
    e_lr  = (mq.size() < DEPTH);
    e_ir  = !mbusy[iss_wa] || (iss_wa == 0);
    e_rs1 = mbusy[ra1] && (ra1 != 0);
    e_rs2 = mbusy[ra2] && (ra2 != 0);
  endtask

  task automatic model_cmp();
    model_eval();
    chk("m_rf_we", 32'(rf_we), 32'(e_we));
    chk("m_wb_hold", 32'(wb_hold), 32'(e_hold));
    chk("m_lu_ready", 32'(lu_ready), 32'(e_lr));
    chk("m_iss_ready", 32'(iss_ready), 32'(e_ir));
    chk("m_rs1_busy", 32'(rs1_busy), 32'(e_rs1));
    chk("m_rs2_busy", 32'(rs2_busy), 32'(e_rs2));
    if (e_we) begin
      chk("m_rf_wa", 32'(rf_wa), 32'(e_wa));
      chk("m_rf_wd", rf_wd, e_wd);
    end
  endtask

  task automatic model_update();
    bit   was_empty, popped, pushok, issok;
    ent_t e;
    model_eval();
    was_empty = (mq.size() == 0);
    popped    = (m_gnt == 2);
    pushok    = lu_valid && e_lr;
    issok     = iss_valid && e_ir && (iss_wa != 0);
    if (popped) begin
      e = mq.pop_front();
      mbusy[e.wa] = 1'b0;
    end
    if (pushok) begin
      e.wa = lu_wa; e.wd = lu_wd;
      mq.push_back(e);
      for (int i = 0; i < outstanding.size(); i++)
        if (outstanding[i] == lu_wa) begin outstanding.delete(i); break; end
    end
    if (issok) begin
      mbusy[iss_wa] = 1'b1;
      outstanding.push_back(iss_wa);
    end
    if (popped || was_empty) mstarve = 0;
    else if (mstarve < STARVE_MAX) mstarve++;
  endtask

  // Caller is at the falling edge with inputs stable.
  task automatic tick();
    model_cmp();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_idle();
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    lu_valid = 0; lu_wa = 0; lu_wd = 0;
    iss_valid = 0; iss_wa = 0; ra1 = 0; ra2 = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic wb_we; logic [4:0] wb_wa; logic [31:0] wb_wd;
    logic lu_valid; logic [4:0] lu_wa; logic [31:0] lu_wd;
    logic iss_valid; logic [4:0] iss_wa; logic [4:0] ra1; logic [4:0] ra2;
    logic x_we; logic [4:0] x_wa; logic [31:0] x_wd;
    logic x_hold; logic x_lr; logic x_ir; logic x_rs1; logic x_rs2;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          wb we,wa,wd       lu v,wa,wd           iss v,wa ra1,ra2  exp we,wa,wd         hold lr ir rs1 rs2
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 7,   7, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             1, 7,   7, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      1, 7, 32'hDEADBEEF,  0, 7,   7, 0,    0, 0, 0,             0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 7,   7, 0,    1, 7, 32'hDEADBEEF,  0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 7,   7, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 32'h1234, 0, 0, 0,           1, 0,   0, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      1, 0, 32'h55,        0, 0,   0, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 0,   0, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{1, 12, 32'hA5A5, 0, 0, 0,          0, 0,   0, 0,    1, 12, 32'hA5A5,     0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             1, 20,  21, 20,  0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 20,  21, 20,  0, 0, 0,             0, 1, 0, 0, 1});
    vecs.push_back('{0, 0, 0,      1, 20, 32'h77,       0, 20,  21, 20,  0, 0, 0,             0, 1, 0, 0, 1});
    vecs.push_back('{1, 3, 32'h9,  0, 0, 0,             0, 20,  21, 20,  1, 3, 32'h9,         0, 1, 0, 0, 1});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 20,  21, 20,  1, 20, 32'h77,       0, 1, 0, 0, 1});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 20,  21, 20,  0, 0, 0,             0, 1, 1, 0, 0});
    // two r0 results fill the buffer behind WB, then drain as suppressed writes
    vecs.push_back('{1, 11, 32'h1, 1, 0, 32'hAA,        0, 0,   0, 0,    1, 11, 32'h1,        0, 1, 1, 0, 0});
    vecs.push_back('{1, 11, 32'h2, 1, 0, 32'hBB,        0, 0,   0, 0,    1, 11, 32'h2,        0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 0,   0, 0,    0, 0, 0,             0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 0,   0, 0,    0, 0, 0,             0, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 0,   0, 0,    0, 0, 0,             0, 1, 1, 0, 0});

    // ---- power-on reset ----
    set_idle();
    rst_n = 1'b0;
    wb_we = 1; wb_wa = 10; lu_valid = 1;
    #1;
    chk("por_rf_we", 32'(rf_we), 0);
    chk("por_wb_hold", 32'(wb_hold), 0);
    chk("por_lu_ready", 32'(lu_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_idle();

    // ---- vector table ----
    for (int i = 0; i < vecs.size(); i++) begin
      wb_we = vecs[i].wb_we; wb_wa = vecs[i].wb_wa; wb_wd = vecs[i].wb_wd;
      lu_valid = vecs[i].lu_valid; lu_wa = vecs[i].lu_wa; lu_wd = vecs[i].lu_wd;
      iss_valid = vecs[i].iss_valid; iss_wa = vecs[i].iss_wa;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      settle();
      chk($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].x_we));
      if (vecs[i].x_we) begin
        chk($sformatf("vec%0d_rf_wa", i), 32'(rf_wa), 32'(vecs[i].x_wa));
        chk($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].x_wd);
      end
      chk($sformatf("vec%0d_wb_hold", i), 32'(wb_hold), 32'(vecs[i].x_hold));
      chk($sformatf("vec%0d_lu_ready", i), 32'(lu_ready), 32'(vecs[i].x_lr));
      chk($sformatf("vec%0d_iss_ready", i), 32'(iss_ready), 32'(vecs[i].x_ir));
      chk($sformatf("vec%0d_rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].x_rs1));
      chk($sformatf("vec%0d_rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].x_rs2));
      tick();
    end
    set_idle();

    // ---- starvation: WB wins four times, then is held for one drain ----
    iss_valid = 1; iss_wa = 3; settle(); tick();
    iss_valid = 0; lu_valid = 1; lu_wa = 3; lu_wd = 32'h11; settle(); tick();
    lu_valid = 0; wb_we = 1; wb_wa = 10;
    for (int k = 0; k < 4; k++) begin
      wb_wd = 32'(k + 100);
      settle();
      chk($sformatf("starve_wb%0d_wa", k), 32'(rf_wa), 10);
      chk($sformatf("starve_wb%0d_hold", k), 32'(wb_hold), 0);
      tick();
    end
    settle();
    chk("starve_forced_hold", 32'(wb_hold), 1);
    chk("starve_forced_wa", 32'(rf_wa), 3);
    chk("starve_forced_wd", rf_wd, 32'h11);
    tick();
    settle();
    chk("starve_after_hold", 32'(wb_hold), 0);
    chk("starve_after_wa", 32'(rf_wa), 10);
    tick();
    set_idle();

    // ---- full buffer behind continuous WB ----
    iss_valid = 1; iss_wa = 1; settle(); tick();
    iss_wa = 2; settle(); tick();
    iss_wa = 6; settle(); tick();
    iss_valid = 0; wb_we = 1; wb_wa = 10; wb_wd = 32'h5;
    lu_valid = 1; lu_wa = 1; lu_wd = 32'h101; settle(); tick();
    lu_wa = 2; lu_wd = 32'h202; settle(); tick();
    lu_wa = 6; lu_wd = 32'h606;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("full_wait%0d_lu_ready", k), 32'(lu_ready), 0);
      chk($sformatf("full_wait%0d_hold", k), 32'(wb_hold), 0);
      tick();
    end
    settle();
    chk("full_drain_hold", 32'(wb_hold), 1);
    chk("full_drain_lu_ready", 32'(lu_ready), 0);
    chk("full_drain_wa", 32'(rf_wa), 1);
    tick();
    settle();
    chk("full_third_accept", 32'(lu_ready), 1);
    tick();
    lu_valid = 0;
    settle();
    chk("full_again", 32'(lu_ready), 0);
    tick();
    wb_we = 0;
    settle(); chk("full_drain2_wa", 32'(rf_wa), 2); tick();
    settle(); chk("full_drain3_wa", 32'(rf_wa), 6); chk("full_drain3_wd", rf_wd, 32'h606); tick();
    set_idle();

    // ---- WAW block on busy destination ----
    iss_valid = 1; iss_wa = 9; settle(); tick();
    settle(); chk("waw_blocked0", 32'(iss_ready), 0); tick();
    lu_valid = 1; lu_wa = 9; lu_wd = 32'h99;
    settle(); chk("waw_blocked1", 32'(iss_ready), 0); tick();
    lu_valid = 0;
    settle();
    chk("waw_pop_wa", 32'(rf_wa), 9);
    chk("waw_blocked_at_pop", 32'(iss_ready), 0);
    tick();
    settle(); chk("waw_released", 32'(iss_ready), 1); tick();
    iss_valid = 0; lu_valid = 1; lu_wa = 9; lu_wd = 32'h98; settle(); tick();
    lu_valid = 0; settle(); tick();
    set_idle();

    // ---- reset mid-operation with two buffered entries ----
    iss_valid = 1; iss_wa = 5; settle(); tick();
    iss_wa = 8; settle(); tick();
    iss_valid = 0; wb_we = 1; wb_wa = 10;
    lu_valid = 1; lu_wa = 5; lu_wd = 32'h5555; settle(); tick();
    lu_wa = 8; lu_wd = 32'h8888; settle(); tick();
    lu_valid = 0; wb_we = 0;
    settle();
    chk("prereset_rf_we", 32'(rf_we), 1);
    chk("prereset_rf_wa", 32'(rf_wa), 5);
    wb_we = 1;
    rst_n = 1'b0;
    #1;
    chk("midreset_rf_we", 32'(rf_we), 0);
    chk("midreset_wb_hold", 32'(wb_hold), 0);
    chk("midreset_lu_ready", 32'(lu_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    set_idle();
    ra1 = 5; iss_wa = 5;
    settle();
    chk("postreset_lu_ready", 32'(lu_ready), 1);
    chk("postreset_iss_ready", 32'(iss_ready), 1);
    chk("postreset_rs1_busy", 32'(rs1_busy), 0);
    chk("postreset_rf_we", 32'(rf_we), 0);
    tick();

    // ---- random traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      wb_we = ($urandom_range(0, 99) < 50);
      wb_wa = 5'($urandom_range(0, 15));
      if (mbusy[wb_wa]) wb_wa = 5'd0;
      wb_wd = $urandom;
      lu_wd = $urandom;
      if (outstanding.size() > 0 && $urandom_range(0, 99) < 40) begin
        lu_valid = 1;
        lu_wa = outstanding[$urandom_range(0, outstanding.size() - 1)];
      end else if ($urandom_range(0, 99) < 5) begin
        lu_valid = 1;
        lu_wa = 5'd0;
      end else begin
        lu_valid = 0;
        lu_wa = 5'($urandom_range(0, 31));
      end
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_wa = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
